// File: rtl/m_lsu_ext.sv
// rtl/m_lsu_ext.sv - MEM-stage load/store unit with lane packing, load extension and mem req/ack handshake
// Requests are checked for alignment/legality at accept; bad ones skip memory and respond with err.
module m_lsu_ext #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    localparam int BE_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [4:0]        req_tag,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BE_W-1:0]   mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [4:0]        rsp_tag,
    output logic              rsp_err,
    output logic              busy
);
    localparam int OFF_W = $clog2(BE_W);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

    state_t              state_q, state_d;
    logic                req_ready_q, req_ready_d;
    logic                busy_q, busy_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [BE_W-1:0]     mem_be_q, mem_be_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic [4:0]          rsp_tag_q, rsp_tag_d;
    logic                rsp_err_q, rsp_err_d;
    logic                we_q, we_d;
    logic [2:0]          op_q, op_d;
    logic [OFF_W-1:0]    off_q, off_d;

    logic [OFF_W-1:0]    in_off;
    logic                misal;
    logic                illegal;
    logic [DATA_W-1:0]   field;
    logic [DATA_W-1:0]   keep;
    logic                sgn;
    logic [DATA_W-1:0]   ext;

    function automatic logic [DATA_W-1:0] size_mask(input logic [2:0] op);
        case (op)
            3'd0:       size_mask = DATA_W'(32'hFFFF_FFFF);
            3'd1, 3'd3: size_mask = DATA_W'(16'hFFFF);
            3'd2, 3'd4: size_mask = DATA_W'(8'hFF);
            default:    size_mask = '1;
        endcase
    endfunction

    function automatic logic [BE_W-1:0] size_be(input logic [2:0] op);
        case (op)
            3'd0:       size_be = BE_W'(4'hF);
            3'd1, 3'd3: size_be = BE_W'(2'h3);
            3'd2, 3'd4: size_be = BE_W'(1'b1);
            default:    size_be = '1;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        busy_d      = busy_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_tag_d   = rsp_tag_q;
        rsp_err_d   = rsp_err_q;
        we_d        = we_q;
        op_d        = op_q;
        off_d       = off_q;

        in_off  = req_addr[OFF_W-1:0];
        misal   = 1'b0;
        illegal = 1'b0;
        case (req_op)
            3'd0:       misal = |req_addr[1:0];
            3'd1, 3'd3: misal = req_addr[0];
            3'd2, 3'd4: misal = 1'b0;
            3'd5: begin
                misal   = |req_addr[2:0];
                illegal = (DATA_W != 64);
            end
            default:    illegal = 1'b1;
        endcase

        // Load path: bring the addressed lane to bit 0, then sign- or zero-fill above the access size.
        field = mem_rdata >> {off_q, 3'b000};
        keep  = size_mask(op_q);
        case (op_q)
            3'd0:    sgn = field[31];
            3'd1:    sgn = field[15];
            3'd2:    sgn = field[7];
            default: sgn = 1'b0;
        endcase
        ext = (field & keep) | ({DATA_W{sgn}} & ~keep);

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d        = req_we;
                    op_d        = req_op;
                    off_d       = in_off;
                    rsp_tag_d   = req_tag;
                    rsp_data_d  = '0;
                    req_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    if (misal || illegal) begin
                        rsp_err_d   = 1'b1;
                        rsp_valid_d = 1'b1;
                        state_d     = S_RESP;
                    end else begin
                        rsp_err_d   = 1'b0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_we;
                        mem_addr_d  = {req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
                        mem_be_d    = size_be(req_op) << in_off;
                        mem_wdata_d = (req_wdata & size_mask(req_op)) << {in_off, 3'b000};
                        state_d     = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (mem_ack) begin
                    mem_req_d   = 1'b0;
                    rsp_data_d  = we_q ? '0 : ext;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                req_ready_d = 1'b1;
                busy_d      = 1'b0;
                mem_req_d   = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_tag_q   <= '0;
            rsp_err_q   <= 1'b0;
            we_q        <= 1'b0;
            op_q        <= '0;
            off_q       <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_tag_q   <= rsp_tag_d;
            rsp_err_q   <= rsp_err_d;
            we_q        <= we_d;
            op_q        <= op_d;
            off_q       <= off_d;
        end
    end

    assign req_ready = req_ready_q;
    assign busy      = busy_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_tag   = rsp_tag_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_m_lsu_ext.sv
// tb/tb_m_lsu_ext.sv - scoreboard bench for m_lsu_ext (32-bit main instance, 64-bit side instance)
module tb_m_lsu_ext;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_op;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_tag;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        rsp_valid, rsp_ready, rsp_err, busy;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_tag;

    logic        x_req_valid, x_req_ready, x_req_we;
    logic [2:0]  x_req_op;
    logic [31:0] x_req_addr, x_mem_addr;
    logic [63:0] x_req_wdata, x_mem_wdata, x_mem_rdata, x_rsp_data;
    logic [4:0]  x_req_tag, x_rsp_tag;
    logic        x_mem_req, x_mem_we, x_mem_ack;
    logic [7:0]  x_mem_be;
    logic        x_rsp_valid, x_rsp_ready, x_rsp_err, x_busy;

    m_lsu_ext #(.DATA_W(32), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_err(rsp_err), .busy(busy)
    );

    m_lsu_ext #(.DATA_W(64), .ADDR_W(32)) dut64 (
        .clk(clk), .rst_n(rst_n), .req_valid(x_req_valid), .req_ready(x_req_ready), .req_we(x_req_we),
        .req_op(x_req_op), .req_addr(x_req_addr), .req_wdata(x_req_wdata), .req_tag(x_req_tag),
        .mem_req(x_mem_req), .mem_we(x_mem_we), .mem_addr(x_mem_addr), .mem_be(x_mem_be),
        .mem_wdata(x_mem_wdata), .mem_ack(x_mem_ack), .mem_rdata(x_mem_rdata), .rsp_valid(x_rsp_valid),
        .rsp_ready(x_rsp_ready), .rsp_data(x_rsp_data), .rsp_tag(x_rsp_tag), .rsp_err(x_rsp_err), .busy(x_busy)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] data; logic [4:0] tag; logic err; } rsp_t;
    typedef struct { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wd; logic [31:0] rdata; } mem_t;

    rsp_t rsp_q[$];
    mem_t mem_q[$];

    int n_vec = 0;
    int n_err = 0;
    int rdy_mode = 0;
    int low_cnt = 0;
    int fixed_delay = -1;
    int last_req_cycles = 0;
    int last_stall = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic note_fail(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s: got timeout/unexpected event, expected orderly completion", nm);
    endtask

    function automatic longint unsigned lmask(input int n);
        return (n >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << n) - 64'd1);
    endfunction

    // Reference: sizes, lanes and extension from plain byte arithmetic.
    function automatic void model(input int dw, input bit we, input int op, input longint unsigned addr,
                                  input longint unsigned wdata, input longint unsigned rdata,
                                  output bit err, output longint unsigned data, output longint unsigned be,
                                  output longint unsigned wd, output longint unsigned maddr);
        int size, off;
        longint unsigned f;
        size = (op == 0) ? 4 : (op == 1 || op == 3) ? 2 : (op == 5) ? 8 : 1;
        off = int'(addr % longint'(dw / 8));
        err = (op > 5) || (op == 5 && dw == 32) || ((addr % longint'(size)) != 0);
        maddr = addr - longint'(off);
        be = ((64'd1 << size) - 64'd1) << off;
        wd = ((wdata & lmask(8 * size)) << (8 * off)) & lmask(dw);
        if (we || err) data = 0;
        else begin
            f = (rdata >> (8 * off)) & lmask(8 * size);
            if ((op == 1 || op == 2 || (op == 0 && dw == 64)) && ((f >> (8 * size - 1)) & 64'd1) == 64'd1)
                f = f | ~lmask(8 * size);
            data = f & lmask(dw);
        end
    endfunction

    task automatic issue(input bit we, input int op, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata);
        bit err;
        longint unsigned d, be, wd, ma;
        rsp_t r;
        mem_t m;
        int t;
        model(32, we, op, {32'd0, addr}, {32'd0, wdata}, {32'd0, rdata}, err, d, be, wd, ma);
        r.data = d[31:0];
        r.tag = 5'($urandom);
        r.err = err;
        rsp_q.push_back(r);
        if (!err) begin
            m.we = we; m.addr = ma[31:0]; m.be = be[3:0]; m.wd = wd[31:0]; m.rdata = rdata;
            mem_q.push_back(m);
        end
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_op = 3'(op); req_addr = addr; req_wdata = wdata; req_tag = r.tag;
        t = 0;
        while (!req_ready && t < 500) begin @(negedge clk); t++; end
        if (t >= 500) note_fail("accept_timeout");
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_op = 3'($urandom);
    endtask

    task automatic drain();
        int t = 0;
        while ((rsp_q.size() != 0 || busy) && t < 1000) begin @(negedge clk); t++; end
        if (t >= 1000) note_fail("drain_timeout");
    endtask

    // Memory responder for the 32-bit instance.
    mem_t cur;
    bit   m_active = 0;
    int   m_cnt = 0;
    int   m_cycles = 0;
    always @(negedge clk) begin
        mem_ack = 1'b0;
        mem_rdata = $urandom;
        if (!rst_n) m_active = 0;
        else if (mem_req) begin
            if (!m_active) begin
                if (mem_q.size() == 0) begin
                    note_fail("mem_req_unexpected");
                    mem_ack = 1'b1;
                end else begin
                    cur = mem_q.pop_front();
                    m_active = 1;
                    m_cnt = (fixed_delay >= 0) ? fixed_delay : $urandom_range(0, 3);
                    m_cycles = 0;
                end
            end
            if (m_active) begin
                m_cycles++;
                chk("mem_we", mem_we, cur.we);
                chk("mem_addr", mem_addr, cur.addr);
                chk("mem_be", mem_be, cur.be);
                chk("mem_wdata", mem_wdata, cur.wd);
                if (m_cnt == 0) begin
                    mem_ack = 1'b1;
                    mem_rdata = cur.rdata;
                    m_active = 0;
                    last_req_cycles = m_cycles;
                end else m_cnt--;
            end
        end
    end

    // Response monitor / scoreboard for the 32-bit instance.
    rsp_t e;
    bit   stalled = 0;
    int   stall_run = 0;
    logic [31:0] sv_data;
    logic [4:0]  sv_tag;
    logic        sv_err;
    always @(negedge clk) begin
        if (!rst_n) begin
            rsp_q.delete();
            stalled = 0;
            stall_run = 0;
        end else begin
            chk("req_ready_vs_busy", req_ready, !busy);
            if (rsp_valid && low_cnt > 0) begin
                rsp_ready = 1'b0;
                low_cnt--;
            end else if (rdy_mode == 1) rsp_ready = 1'b1;
            else rsp_ready = ($urandom_range(0, 3) != 0);
            if (rsp_valid) begin
                if (stalled) begin
                    chk("rsp_data_stable", rsp_data, sv_data);
                    chk("rsp_tag_stable", rsp_tag, sv_tag);
                    chk("rsp_err_stable", rsp_err, sv_err);
                end
                if (rsp_ready) begin
                    if (rsp_q.size() == 0) note_fail("rsp_unexpected");
                    else begin
                        e = rsp_q.pop_front();
                        chk("rsp_data", rsp_data, e.data);
                        chk("rsp_tag", rsp_tag, e.tag);
                        chk("rsp_err", rsp_err, e.err);
                    end
                    last_stall = stall_run;
                    stall_run = 0;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    stall_run++;
                    sv_data = rsp_data; sv_tag = rsp_tag; sv_err = rsp_err;
                end
            end
        end
    end

    task automatic do64(input bit we, input int op, input logic [31:0] addr, input logic [63:0] wdata,
                        input logic [63:0] rdata);
        bit err;
        longint unsigned d, be, wd, ma;
        logic [4:0] tag;
        int t;
        model(64, we, op, {32'd0, addr}, wdata, rdata, err, d, be, wd, ma);
        tag = 5'($urandom);
        @(negedge clk);
        x_req_valid = 1'b1; x_req_we = we; x_req_op = 3'(op); x_req_addr = addr; x_req_wdata = wdata;
        x_req_tag = tag;
        @(posedge clk);
        #1;
        x_req_valid = 1'b0;
        if (!err) begin
            t = 0;
            while (!x_mem_req && t < 50) begin @(negedge clk); t++; end
            if (t >= 50) note_fail("x_mem_req_timeout");
            chk("x_mem_we", x_mem_we, we);
            chk("x_mem_addr", x_mem_addr, ma[31:0]);
            chk("x_mem_be", x_mem_be, be[7:0]);
            chk("x_mem_wdata", x_mem_wdata, wd);
            x_mem_ack = 1'b1; x_mem_rdata = rdata;
            @(posedge clk);
            #1;
            x_mem_ack = 1'b0; x_mem_rdata = {$urandom, $urandom};
        end else chk("x_mem_req_on_err", x_mem_req, 1'b0);
        t = 0;
        while (!x_rsp_valid && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) note_fail("x_rsp_timeout");
        chk("x_rsp_data", x_rsp_data, d);
        chk("x_rsp_tag", x_rsp_tag, tag);
        chk("x_rsp_err", x_rsp_err, err);
        @(negedge clk);
    endtask

    initial begin
        int t;
        req_valid = 0; req_we = 0; req_op = 0; req_addr = 0; req_wdata = 0; req_tag = 0;
        rsp_ready = 1; mem_ack = 0; mem_rdata = 0;
        x_req_valid = 0; x_req_we = 0; x_req_op = 0; x_req_addr = 0; x_req_wdata = 0; x_req_tag = 0;
        x_rsp_ready = 1; x_mem_ack = 0; x_mem_rdata = 0;
        rst_n = 0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_rsp_tag", rsp_tag, 5'd0);
        chk("rst_mem_be", mem_be, 4'd0);
        chk("rst_x_req_ready", x_req_ready, 1'b1);
        rst_n = 1;

        issue(0, 2, 32'h1003, 32'h0, 32'h80112233);
        issue(0, 3, 32'h2002, 32'h0, 32'hBEEF0000);
        issue(0, 1, 32'h2002, 32'h0, 32'hBEEF0000);
        issue(1, 2, 32'h11, 32'hAB, $urandom);
        drain();

        rdy_mode = 1;
        issue(0, 0, 32'h6, 32'h0, 32'h0);
        chk("err_rsp_valid_t1", rsp_valid, 1'b1);
        chk("err_rsp_err_t1", rsp_err, 1'b1);
        chk("err_mem_req", mem_req, 1'b0);
        chk("err_busy_t1", busy, 1'b1);
        @(posedge clk);
        #1;
        chk("err_busy_t2", busy, 1'b0);
        drain();

        fixed_delay = 4;
        low_cnt = 3;
        issue(0, 0, 32'h100, 32'h0, 32'h12345678);
        drain();
        chk("mem_req_hold_cycles", last_req_cycles, 5);
        chk("rsp_stall_cycles", last_stall, 3);

        fixed_delay = 30;
        issue(0, 0, 32'h200, 32'h0, 32'hCAFEF00D);
        @(negedge clk);
        #1;
        rst_n = 0;
        #1;
        chk("async_rst_mem_req", mem_req, 1'b0);
        chk("async_rst_req_ready", req_ready, 1'b1);
        chk("async_rst_busy", busy, 1'b0);
        chk("async_rst_rsp_valid", rsp_valid, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        fixed_delay = -1;
        rdy_mode = 0;

        for (int i = 0; i < 300; i++)
            issue(1'($urandom), $urandom_range(0, 7), 32'h4000 + 32'($urandom_range(0, 31)), $urandom, $urandom);
        drain();
        t = 0;
        while (mem_q.size() != 0 && t < 10) begin @(negedge clk); t++; end
        chk("mem_q_empty", 64'(mem_q.size()), 64'd0);

        do64(0, 5, 32'h8, 64'd0, 64'h8123_4567_89AB_CDEF);
        do64(0, 0, 32'h4, 64'd0, 64'h8000_0000_1234_5678);
        do64(0, 5, 32'h4, 64'd0, 64'h1);
        do64(1, 5, 32'h10, 64'hDEAD_BEEF_0BAD_F00D, 64'd0);
        for (int i = 0; i < 60; i++)
            do64(1'($urandom), $urandom_range(0, 7), 32'h8000 + 32'($urandom_range(0, 31)),
                 {$urandom, $urandom}, {$urandom, $urandom});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
